// File: rtl/mac16_rr_scheduler.sv
// Round-robin issue onto a shared fixed-latency MAC; tags ride a shadow pipe into a credit-protected result FIFO.
// Define MAC16_SCHED_STATS_EN to enable the stat_issues/stat_stalls counters (tied to zero otherwise).
module mac16_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [$clog2(NUM_REQ)-1:0]     mac_sel,
  input  logic [DATA_W-1:0]              mac_result,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATA_W-1:0]              res_data,
  output logic [$clog2(NUM_REQ)-1:0]     res_tag,
  output logic [$clog2(LATENCY+1)-1:0]   inflight,
  output logic                           busy,
  output logic [31:0]                    stat_issues,
  output logic [31:0]                    stat_stalls
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] sel_q;
  logic [TAG_W-1:0] win_idx;
  logic             found;
  logic             credit_ok;
  logic             issue;
  int unsigned      cand;

  logic [INF_W-1:0] inflight_q;
  logic [CNT_W-1:0] fifo_cnt;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[TAG_W'(cand)]) begin
        found   = 1'b1;
        win_idx = TAG_W'(cand);
      end
    end
  end

  // Pops in the current cycle are deliberately not counted as credit.
  assign credit_ok = (32'(inflight_q) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH);
  assign issue     = !reset && enable && found && credit_ok;
  assign gnt       = issue ? (NUM_REQ'(1) << win_idx) : '0;
  assign mac_sel   = issue ? win_idx : sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      sel_q <= '0;
    end else if (issue) begin
      ptr_q <= (32'(win_idx) == 32'(NUM_REQ - 1)) ? '0 : win_idx + TAG_W'(1);
      sel_q <= win_idx;
    end
  end

  logic [LATENCY-1:0] sh_vld;
  logic [TAG_W-1:0]   sh_tag [LATENCY];
  logic               exit_v;
  logic [TAG_W-1:0]   exit_tag;

  assign exit_v   = sh_vld[LATENCY-1];
  assign exit_tag = sh_tag[LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_vld <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) sh_tag[s] <= '0;
    end else begin
      sh_vld[0] <= issue;
      sh_tag[0] <= win_idx;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        sh_vld[s] <= sh_vld[s-1];
        sh_tag[s] <= sh_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      case ({issue, exit_v})
        2'b10:   inflight_q <= inflight_q + INF_W'(1);
        2'b01:   inflight_q <= inflight_q - INF_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign push      = exit_v;
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= mac_result;
      mem_tag[wr_ptr]  <= exit_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (32'(wr_ptr) == 32'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (32'(rd_ptr) == 32'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign res_data = res_valid ? mem_data[rd_ptr] : '0;
  assign res_tag  = res_valid ? mem_tag[rd_ptr]  : '0;
  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0) || res_valid;

  no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_cnt == CNT_W'(FIFO_DEPTH)));

`ifdef MAC16_SCHED_STATS_EN
  logic stall;
  assign stall = enable && (|req) && !issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issues <= '0;
      stat_stalls <= '0;
    end else begin
      if (issue && stat_issues != '1) stat_issues <= stat_issues + 32'd1;
      if (stall && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`else
  assign stat_issues = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_mac16_rr_scheduler.sv
// Scoreboard bench for mac16_rr_scheduler: a behavioural MAC pipe feeds mac_result, results are checked in issue order.
module tb_mac16_rr_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int LATENCY    = 6;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [3:0]        req;
  logic [3:0]        gnt;
  logic [1:0]        mac_sel;
  logic [DATA_W-1:0] mac_result;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_tag;
  logic [2:0]        inflight;
  logic              busy;
  logic [31:0]       stat_issues;
  logic [31:0]       stat_stalls;

  always #5 clk = ~clk;

  mac16_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .gnt(gnt), .mac_sel(mac_sel),
    .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .inflight(inflight), .busy(busy),
    .stat_issues(stat_issues), .stat_stalls(stat_stalls)
  );

  typedef struct packed { logic [1:0] tag; logic [31:0] data; } sb_t;
  sb_t         sb[$];
  sb_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_n  = 0;
  int unsigned mac_n  = 0;

  function automatic logic [31:0] exp_data(int unsigned n, logic [1:0] t);
    return 32'hA500_0000 | (n << 4) | 32'(t);
  endfunction

  // Behavioural MAC: LATENCY-deep pipe, result tracks the operand select sampled at the issue edge.
  logic [31:0] mac_pipe [LATENCY];
  assign mac_result = mac_pipe[LATENCY-1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) mac_pipe[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) mac_pipe[i] <= mac_pipe[i-1];
      if (|gnt) begin
        mac_pipe[0] <= 32'hA500_0000 | (mac_n << 4) | 32'(mac_sel);
        mac_n <= mac_n + 1;
      end else begin
        mac_pipe[0] <= 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got tag=%0d data=%h, required none", res_tag, res_data);
      end else begin
        mon_e = sb.pop_front();
        if (res_tag !== mon_e.tag || res_data !== mon_e.data) begin
          errors++;
          $display("FAIL result got tag=%0d data=%h required tag=%0d data=%h",
                   res_tag, res_data, mon_e.tag, mon_e.data);
        end
      end
    end
  end

  task automatic do_reset();
    req = '0; enable = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b1; sb.delete();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    req = '0; res_ready = 1'b1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got busy=%b pending=%0d required busy=0 pending=0", name, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = 4'hF; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0 || mac_sel !== 2'd0 || res_valid !== 1'b0 || res_data !== 32'd0 ||
        res_tag !== 2'd0 || inflight !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b sel=%0d v=%b d=%h t=%0d inf=%0d busy=%b required all zero",
               gnt, mac_sel, res_valid, res_data, res_tag, inflight, busy);
    end
    checks++;
    if (stat_issues !== 32'd0 || stat_stalls !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d required 0/0", stat_issues, stat_stalls);
    end
    req = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] exp_g;
    logic       exp_v;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req = (c < 3) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      exp_g = (c < 3) ? 4'b0001 : 4'b0000;
      exp_v = (c >= 7 && c <= 9);
      checks++;
      if (gnt !== exp_g) begin
        errors++; $display("FAIL single_gnt c=%0d got %b required %b", c, gnt, exp_g);
      end
      checks++;
      if (res_valid !== exp_v) begin
        errors++; $display("FAIL single_valid c=%0d got %b required %b", c, res_valid, exp_v);
      end
      if (exp_g != 0) begin
        checks++;
        if (mac_sel !== 2'd0) begin
          errors++; $display("FAIL single_sel c=%0d got %0d required 0", c, mac_sel);
        end
        sb.push_back({2'd0, exp_data(exp_n, 2'd0)});
        exp_n++;
      end
    end
    drain("single");
  endtask

  task automatic test_fairness();
    logic [1:0] t;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req = 4'hF;
      @(negedge clk);
      t = 2'(c % 4);
      checks++;
      if (gnt !== (4'b0001 << t) || mac_sel !== t) begin
        errors++; $display("FAIL fair_gnt c=%0d got gnt=%b sel=%0d required idx %0d", c, gnt, mac_sel, t);
      end
      sb.push_back({t, exp_data(exp_n, t)});
      exp_n++;
    end
    @(posedge clk); #1;
    drain("fair");
  endtask

  task automatic test_credit_stall();
    logic       has;
    logic [1:0] t;
    int         exp_iss = 0;
    int         exp_stl = 0;
    logic [31:0] req_iss, req_stl;
    do_reset();
    res_ready = 1'b0;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      req = 4'b0011;
      res_ready = (c == 20);
      @(negedge clk);
      has = (c < 8) || (c == 21);
      t   = (c < 8) ? 2'(c % 2) : 2'd0;
      checks++;
      if (gnt !== (has ? (4'b0001 << t) : 4'b0000)) begin
        errors++; $display("FAIL stall_gnt c=%0d got %b required issue=%b idx=%0d", c, gnt, has, t);
      end
      if (has) begin
        exp_iss++;
        sb.push_back({t, exp_data(exp_n, t)});
        exp_n++;
      end else begin
        exp_stl++;
      end
      if (c >= 8 && c <= 19) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL stall_busy c=%0d got %b required 1", c, busy);
        end
      end
    end
    @(posedge clk); #1;
    req = '0;
`ifdef MAC16_SCHED_STATS_EN
    req_iss = 32'(exp_iss);
    req_stl = 32'(exp_stl);
`else
    req_iss = 32'd0;
    req_stl = 32'd0;
`endif
    checks++;
    if (stat_issues !== req_iss || stat_stalls !== req_stl) begin
      errors++;
      $display("FAIL stall_stats got %0d/%0d required %0d/%0d", stat_issues, stat_stalls, req_iss, req_stl);
    end
    drain("stall");
  endtask

  task automatic test_enable_drop();
    logic exp_v, exp_b;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      req = 4'hF;
      enable = (c < 2);
      @(negedge clk);
      exp_v = (c == 7 || c == 8);
      exp_b = (c >= 1 && c <= 8);
      checks++;
      if (gnt !== ((c < 2) ? (4'b0001 << c) : 4'b0000)) begin
        errors++; $display("FAIL endrop_gnt c=%0d got %b", c, gnt);
      end
      checks++;
      if (res_valid !== exp_v || busy !== exp_b) begin
        errors++; $display("FAIL endrop_state c=%0d got v=%b busy=%b required v=%b busy=%b",
                           c, res_valid, busy, exp_v, exp_b);
      end
      if (c < 2) begin
        sb.push_back({2'(c), exp_data(exp_n, 2'(c))});
        exp_n++;
      end
    end
    enable = 1'b1;
    drain("endrop");
  endtask

  task automatic test_async_reset();
    do_reset();
    res_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      req = (c < 6) ? 4'hF : 4'h0;
      @(negedge clk);
      checks++;
      if (gnt !== ((c < 6) ? (4'b0001 << (c % 4)) : 4'b0000)) begin
        errors++; $display("FAIL areset_gnt c=%0d got %b", c, gnt);
      end
      if (c < 6) begin
        sb.push_back({2'(c % 4), exp_data(exp_n, 2'(c % 4))});
        exp_n++;
      end
    end
    checks++;
    if (inflight !== 3'd4 || res_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre got inf=%0d v=%b required inf=4 v=1", inflight, res_valid);
    end
    #1 reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (res_valid !== 1'b0 || inflight !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_async got v=%b inf=%0d busy=%b required 0/0/0", res_valid, inflight, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0; req = 4'hF; res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL areset_first_gnt got %b required 0001", gnt);
    end
    sb.push_back({2'd0, exp_data(exp_n, 2'd0)});
    exp_n++;
    @(posedge clk); #1;
    drain("areset");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; req = '0; res_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_credit_stall();
    test_enable_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
